bus_arb_mux: RTL and testbench

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

---
 rtl/bus_arb_mux.sv | 97 +++++++++
 tb/tb_bus_arb_mux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_arb_mux.sv
// Multi-channel arbiter feeding a one-word registered output stage.
// Fixed-priority or round-robin grant, with full throughput under backpressure.
module bus_arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]         out_chan,
  input  logic                      out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [CHAN_W-1:0] out_chan_q,  out_chan_d;
  logic [CHAN_W-1:0] last_grant_q, last_grant_d;

  logic              load_en;
  logic              grant_found;
  logic [CHAN_W-1:0] grant_idx;
  logic [CHAN_W-1:0] cand_idx;

  assign load_en = !out_valid_q || out_ready;

  // Grant search; looks only at requests, mode and pointer, never at data.
  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    if (!mode) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = CHAN_W'(i);
        end
      end
    end else begin
      for (int off = 1; off <= CHANNELS; off++) begin
        cand_idx = CHAN_W'((int'(last_grant_q) + off) % CHANNELS);
        if (!grant_found && in_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // Reset gates in_ready so nothing is accepted while the block is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_found)
      in_ready = CHANNELS'(1) << grant_idx;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d   = in_data[grant_idx*WIDTH +: WIDTH];
        out_chan_d   = grant_idx;
        last_grant_d = grant_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= CHAN_W'(CHANNELS - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux (WIDTH=8, CHANNELS=4) with hand-computed expectations.
module tb_bus_arb_mux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CHAN_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      mode;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [CHAN_W-1:0]         out_chan;
  logic                      out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arb_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] chan, input logic [7:0] data);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_chan"},  32'(out_chan),  32'(chan));
    check({tag, "_data"},  32'(out_data),  32'(data));
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    logic [1:0] gap_exp [4];
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    gap_exp = '{2'd0, 2'd1, 2'd0, 2'd1};

    // Reset with all channels requesting
    rst_n = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_in_ready2", 32'(in_ready),  32'h0);
    rst_n = 1'b1;
    #1;

    // Round-robin from fresh reset: channel 0 first
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rr%0d", i), rr_exp[i], 8'hA0 + 8'(rr_exp[i]));
    end

    // One more grant to hold A1 on channel 1, then stall
    tick();
    check_out("pre_stall", 2'd1, 8'hA1);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'h0);
      tick();
      check_out($sformatf("stall%0d", i), 2'd1, 8'hA1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("unstall", 2'd2, 8'hA2);

    // Fixed priority: lowest requesting index wins every cycle
    mode = 1'b0; in_valid = 4'b1010;
    in_data = {8'h33, 8'h00, 8'h11, 8'h00};
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("fp%0d_ready", i), 32'(in_ready), 32'b0010);
      tick();
      check_out($sformatf("fp%0d", i), 2'd1, 8'h11);
    end

    // Switch to round-robin: last_grant=1 retained, so channel 2 next
    mode = 1'b1; in_valid = 4'b1111;
    in_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    #1;
    check("mode_sw_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("mode_sw", 2'd2, 8'hB2);

    // Wrap with gaps from last_grant=2
    in_valid = 4'b0011;
    in_data = {8'h00, 8'h00, 8'hC1, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("gap%0d_ready", i), 32'(in_ready), 32'(4'b0001 << gap_exp[i]));
      tick();
      check_out($sformatf("gap%0d", i), gap_exp[i], 8'hC0 + 8'(gap_exp[i]));
    end

    // No request: out_valid drops, data and chan hold
    in_valid = 4'b0000;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data",  32'(out_data),  32'hC1);
    check("idle_chan",  32'(out_chan),  32'd1);

    // Request withdrawn during stall must not move last_grant
    in_valid = 4'b0100;
    in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    tick();
    check_out("wd_load", 2'd2, 8'hD2);
    out_ready = 1'b0; in_valid = 4'b1000;
    tick();
    in_valid = 4'b0000;
    tick();
    check_out("wd_hold", 2'd2, 8'hD2);
    out_ready = 1'b1; in_valid = 4'b1111;
    #1;
    check("wd_ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("wd_next", 2'd3, 8'hD3);

    // Reset pulsed mid-stall discards the held word
    out_ready = 1'b0;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'h0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("post_rst", 2'd0, 8'hA0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
